keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with scan-level debounce and one-cycle key strobe.
// Optional auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_DRIVE0 | column 0 driven low, settle, sample rows into hit record
// S_DRIVE1 | column 1 driven low, settle, sample rows into hit record
// S_DRIVE2 | column 2 driven low, settle, sample rows into hit record
// S_DRIVE3 | column 3 driven low, settle, sample rows into hit record
// S_EVAL   | all columns released, classify scan, debounce, accept
module keypad_scanner #(
   parameter int unsigned SETTLE_CYCLES      = 500,
   parameter int unsigned DEBOUNCE_SCANS     = 250,
   parameter int unsigned REPEAT_DELAY_SCANS = 12500,
   parameter int unsigned REPEAT_RATE_SCANS  = 2500
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] KeyCode,
   output logic       KeyValid,
   output logic       KeyHeld
);

   // DRIVE encodings equal the column index so the state walks by increment into EVAL
   localparam logic [2:0] S_DRIVE0 = 3'd0;
   localparam logic [2:0] S_DRIVE1 = 3'd1;
   localparam logic [2:0] S_DRIVE2 = 3'd2;
   localparam logic [2:0] S_DRIVE3 = 3'd3;
   localparam logic [2:0] S_EVAL   = 3'd4;

   localparam logic [1:0] C_NONE  = 2'd0;
   localparam logic [1:0] C_KEY   = 2'd1;
   localparam logic [1:0] C_MULTI = 2'd2;

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] DEB_TARGET  = 16'(DEBOUNCE_SCANS);

   logic [3:0]  r_row_s1;
   logic [3:0]  r_row_s2;
   logic [2:0]  r_state;
   logic [15:0] r_settle_cnt;
   logic [15:0] r_hit;
   logic [1:0]  r_prev_class;
   logic [3:0]  r_prev_code;
   logic [15:0] r_stable_cnt;
   logic [3:0]  r_key_code;
   logic        r_key_valid;
   logic        r_key_held;

   logic [1:0]  w_col_idx;
   logic        w_eval;
   logic        w_settle_done;
   logic [15:0] w_hit_set;
   logic [4:0]  w_hit_cnt;
   logic [3:0]  w_hit_idx;
   logic [1:0]  w_class;
   logic [3:0]  w_code;
   logic        w_same;
   logic        w_stable_sat;
   logic [15:0] w_stable_next;
   logic        w_reached;
   logic        w_differs;
   logic        w_accept;
   logic        w_accept_key;
   logic        w_rpt_fire;

   assign w_col_idx     = r_state[1:0];
   assign w_eval        = (r_state == S_EVAL);
   assign w_settle_done = (r_settle_cnt == SETTLE_LAST);

   always_comb begin
      w_hit_set = '0;
      for (int r = 0; r < 4; r++) begin
         w_hit_set[r*4 + int'(w_col_idx)] = ~r_row_s2[r];
      end
   end

   always_comb begin
      w_hit_cnt = '0;
      w_hit_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (r_hit[i]) begin
            w_hit_cnt = w_hit_cnt + 5'd1;
            w_hit_idx = 4'(i);
         end
      end
   end

   assign w_class = (w_hit_cnt == 5'd0) ? C_NONE :
                    (w_hit_cnt == 5'd1) ? C_KEY  : C_MULTI;
   assign w_code  = (w_class == C_KEY) ? w_hit_idx : 4'd0;

   assign w_same        = (w_class == r_prev_class) && (w_code == r_prev_code);
   assign w_stable_sat  = (r_stable_cnt == 16'hFFFF);
   assign w_stable_next = !w_same     ? 16'd1 :
                          w_stable_sat ? r_stable_cnt : r_stable_cnt + 16'd1;
   // A saturated count that stays put has not "become" the target again
   assign w_reached     = (w_stable_next == DEB_TARGET) && !(w_same && w_stable_sat);
   assign w_differs     = (w_class == C_KEY) ? (!r_key_held || (w_code != r_key_code))
                                             : r_key_held;
   assign w_accept      = w_eval && w_reached && (w_class != C_MULTI) && w_differs;
   assign w_accept_key  = w_accept && (w_class == C_KEY);

`ifdef KEYPAD_REPEAT_EN
   localparam logic [15:0] RPT_DELAY = 16'(REPEAT_DELAY_SCANS);
   localparam logic [15:0] RPT_RATE  = 16'(REPEAT_RATE_SCANS);

   logic [15:0] r_rpt_cnt;
   logic        w_persist;

   assign w_persist  = r_key_held && w_same && (w_class == C_KEY) && (w_code == r_key_code);
   assign w_rpt_fire = w_eval && !w_accept && w_persist && (r_rpt_cnt == 16'd1);

   // Down-counter to the next repeat; any break in the held result restarts the delay
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         r_rpt_cnt <= '0;
      end else if (w_eval) begin
         if (w_accept || !w_persist) begin
            r_rpt_cnt <= RPT_DELAY;
         end else if (r_rpt_cnt == 16'd1) begin
            r_rpt_cnt <= RPT_RATE;
         end else if (r_rpt_cnt != 16'd0) begin
            r_rpt_cnt <= r_rpt_cnt - 16'd1;
         end
      end
   end
`else
   assign w_rpt_fire = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         r_row_s1     <= 4'hF;
         r_row_s2     <= 4'hF;
         r_state      <= S_DRIVE0;
         r_settle_cnt <= '0;
         r_hit        <= '0;
         r_prev_class <= C_NONE;
         r_prev_code  <= '0;
         r_stable_cnt <= '0;
         r_key_code   <= '0;
         r_key_valid  <= 1'b0;
         r_key_held   <= 1'b0;
      end else begin
         r_row_s1    <= Row;
         r_row_s2    <= r_row_s1;
         r_key_valid <= 1'b0;
         if (w_eval) begin
            r_state      <= S_DRIVE0;
            r_hit        <= '0;
            r_prev_class <= w_class;
            r_prev_code  <= w_code;
            r_stable_cnt <= w_stable_next;
            r_key_valid  <= w_accept_key | w_rpt_fire;
            if (w_accept) begin
               r_key_held <= (w_class == C_KEY);
               if (w_class == C_KEY) begin
                  r_key_code <= w_code;
               end
            end
         end else if (w_settle_done) begin
            r_settle_cnt <= '0;
            r_hit        <= r_hit | w_hit_set;
            r_state      <= r_state + 3'd1;
         end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
         end
      end
   end

   assign Col      = w_eval ? 4'b1111 : ~(4'b0001 << w_col_idx);
   assign KeyCode  = r_key_code;
   assign KeyValid = r_key_valid;
   assign KeyHeld  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: keypad matrix model, scan-level reference model and scoreboard.
// Build with KEYPAD_REPEAT_EN defined to exercise the auto-repeat variant.
module tb_keypad_scanner;

   localparam int SETTLE = 4;
   localparam int DEB    = 3;
   localparam int RDELAY = 5;
   localparam int RRATE  = 2;
   localparam int SCAN   = 4*SETTLE + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys = '0;

   typedef struct packed {
      int         cyc;
      logic [3:0] code;
   } exp_t;

   exp_t q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;

   // reference model state (scan-level view of the keypad)
   int          n = 0;
   logic [15:0] seen = '0;
   int          m_pclass = 0;
   int          m_pcode  = 0;
   int          m_stable = 0;
   logic        m_held   = 1'b0;
   logic [3:0]  m_code   = '0;
   int          m_rp     = 0;
   int          md_off;
   int          md_c;

   // monitor state
   int          mon_off;
   logic [3:0]  mon_col;
   logic        prev_valid = 1'b0;
   exp_t        mon_e;

   keypad_scanner #(
      .SETTLE_CYCLES      (SETTLE),
      .DEBOUNCE_SCANS     (DEB),
      .REPEAT_DELAY_SCANS (RDELAY),
      .REPEAT_RATE_SCANS  (RRATE)
   ) dut (
      .CLOCK_50 (clk),
      .Reset    (rst),
      .Row      (row),
      .Col      (col),
      .KeyCode  (key_code),
      .KeyValid (key_valid),
      .KeyHeld  (key_held)
   );

   always #5 clk = ~clk;

   // physical matrix: a pressed key pulls its row low when its column is driven low
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, n, $time);
      end
   endtask

   task automatic model_reset();
      n        = 0;
      seen     = '0;
      m_pclass = 0;
      m_pcode  = 0;
      m_stable = 0;
      m_held   = 1'b0;
      m_code   = '0;
      m_rp     = 0;
      q.delete();
   endtask

   task automatic push_exp(input int cyc, input logic [3:0] code);
      exp_t e;
      e.cyc  = cyc;
      e.code = code;
      q.push_back(e);
   endtask

   // one scan's worth of debounce/acceptance decisions, expressed on whole-scan results
   task automatic eval_scan();
      int   cls;
      int   code;
      int   ones;
      bit   same;
      bit   acc_key;
      ones = $countones(seen);
      cls  = (ones == 0) ? 0 : (ones == 1) ? 1 : 2;
      code = 0;
      if (cls == 1) begin
         for (int i = 0; i < 16; i++) if (seen[i]) code = i;
      end
      same = (cls == m_pclass) && (code == m_pcode);
      if (same) begin
         if (m_stable < 65535) m_stable++;
      end else begin
         m_stable = 1;
      end
      m_pclass = cls;
      m_pcode  = code;
      acc_key  = 1'b0;
      if (m_stable == DEB && cls != 2) begin
         if (cls == 1 && (!m_held || code != int'(m_code))) begin
            acc_key = 1'b1;
            m_held  = 1'b1;
            m_code  = 4'(code);
            m_rp    = 0;
            push_exp(n + 1, 4'(code));
         end else if (cls == 0 && m_held) begin
            m_held = 1'b0;
         end
      end
`ifdef KEYPAD_REPEAT_EN
      if (!acc_key) begin
         if (m_held && same && cls == 1 && code == int'(m_code)) begin
            m_rp++;
            if (m_rp == RDELAY || (m_rp > RDELAY && ((m_rp - RDELAY) % RRATE) == 0))
               push_exp(n + 1, m_code);
         end else begin
            m_rp = 0;
         end
      end
`endif
      seen = '0;
   endtask

   // model: the row value that reaches the sampling flop is the one present two cycles before the sample edge
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            model_reset();
         end else begin
            md_off = n % SCAN;
            if (md_off < 4*SETTLE && (md_off % SETTLE) == SETTLE-3) begin
               md_c = md_off / SETTLE;
               for (int r = 0; r < 4; r++) begin
                  if (keys[r*4+md_c]) seen[r*4+md_c] = 1'b1;
               end
            end
            if (md_off == SCAN-1) eval_scan();
            n++;
         end
      end
   end

   // monitor: column schedule, held level, and strobes against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            mon_off = n % SCAN;
            mon_col = (mon_off < 4*SETTLE) ? ~(4'b0001 << (mon_off / SETTLE)) : 4'b1111;
            chk("col", int'(col), int'(mon_col));
            chk("held", int'(key_held), int'(m_held));
            chk("code", int'(key_code), int'(m_code));
            while (q.size() > 0 && q[0].cyc < n) begin
               n_checks++;
               n_fail++;
               $display("FAIL missed_valid: no strobe, expected at cycle %0d code %0d (now cycle %0d)",
                        q[0].cyc, q[0].code, n);
               void'(q.pop_front());
            end
            if (key_valid) begin
               n_pulses++;
               chk("valid_single", int'(prev_valid), 0);
               if (q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL spurious_valid: strobe with code %0d at cycle %0d, none expected", key_code, n);
               end else begin
                  mon_e = q.pop_front();
                  chk("valid_cycle", n, mon_e.cyc);
                  chk("valid_code", int'(key_code), int'(mon_e.code));
               end
            end
            prev_valid = key_valid;
         end
      end
   end

   task automatic wait_cyc(input int k);
      repeat (k) @(negedge clk);
      #1;
   endtask

   task automatic align_scan();
      for (int i = 0; i < SCAN && (n % SCAN) != 0; i++) wait_cyc(1);
   endtask

   int p0;
   int dur;
   int sel;
   int b0;
   int b1;
   int exp_rpt;

   initial begin
`ifdef KEYPAD_REPEAT_EN
      exp_rpt = 4;
`else
      exp_rpt = 1;
`endif
      wait_cyc(3);
      chk("rst_col", int'(col), 4'b1110);
      chk("rst_code", int'(key_code), 0);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_held", int'(key_held), 0);
      rst = 1'b0;
      wait_cyc(2*SCAN);

      // single key row 2 / col 1
      p0 = n_pulses;
      align_scan();
      keys = 16'(1 << 9);
      wait_cyc(6*SCAN);
      chk("hold9_pulses", n_pulses - p0, 1);
      chk("hold9_held", int'(key_held), 1);
      chk("hold9_code", int'(key_code), 9);

      // release: held drops, code kept, no strobe
      p0 = n_pulses;
      keys = '0;
      wait_cyc(6*SCAN);
      chk("rel9_pulses", n_pulses - p0, 0);
      chk("rel9_held", int'(key_held), 0);
      chk("rel9_code", int'(key_code), 9);

      // contact bounce then settle
      p0 = n_pulses;
      for (int i = 0; i < 12; i++) begin
         keys = keys ^ 16'(1 << 9);
         wait_cyc(5);
      end
      keys = 16'(1 << 9);
      wait_cyc(6*SCAN);
      chk("bounce_pulses", n_pulses - p0, 1);
      chk("bounce_code", int'(key_code), 9);
      keys = '0;
      wait_cyc(6*SCAN);

      // two keys together are never accepted
      p0 = n_pulses;
      keys = 16'((1 << 1) | (1 << 6));
      wait_cyc(6*SCAN);
      chk("multi_pulses", n_pulses - p0, 0);
      chk("multi_held", int'(key_held), 0);
      chk("multi_code", int'(key_code), 9);
      keys = 16'(1 << 1);
      wait_cyc(6*SCAN);
      chk("multi_rel_pulses", n_pulses - p0, 1);
      chk("multi_rel_code", int'(key_code), 1);

      // reset mid-scan while a key is held
      keys = 16'(1 << 9);
      wait_cyc(6*SCAN);
      wait_cyc($urandom_range(1, SCAN-1));
      rst = 1'b1;
      #1;
      chk("midrst_col", int'(col), 4'b1110);
      chk("midrst_code", int'(key_code), 0);
      chk("midrst_valid", int'(key_valid), 0);
      chk("midrst_held", int'(key_held), 0);
      wait_cyc(2);
      rst = 1'b0;
      keys = '0;
      wait_cyc(6*SCAN);

      // long hold of code 4 (auto-repeat when built in)
      p0 = n_pulses;
      align_scan();
      keys = 16'(1 << 4);
      wait_cyc(13*SCAN);
      keys = '0;
      wait_cyc(6*SCAN);
      chk("hold4_pulses", n_pulses - p0, exp_rpt);

      // randomized key activity
      for (int s = 0; s < 150; s++) begin
         dur = $urandom_range(5, 120);
         sel = $urandom_range(0, 9);
         b0  = $urandom_range(0, 15);
         b1  = $urandom_range(0, 15);
         if (sel < 4)      keys = '0;
         else if (sel < 8) keys = 16'(1 << b0);
         else if (sel < 9) keys = 16'((1 << b0) | (1 << b1));
         else              keys = 16'(1 << b0);
         if (sel == 9) begin
            for (int t = 0; t < dur; t += 5) begin
               keys = keys ^ 16'(1 << b0);
               wait_cyc(5);
            end
         end else begin
            wait_cyc(dur);
         end
      end
      keys = '0;
      wait_cyc(6*SCAN);
      chk("queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
